branch_ctl: RTL
===============

BRANCH_CTL -- requirements
Module: branch_ctl

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately regardless of clk.
REQ-004 N  input  1  negative flag from the NZP flag register.
REQ-005 Z  input  1  zero flag from the NZP flag register.
REQ-006 P  input  1  positive flag from the NZP flag register.
REQ-007 IR  input  16  instruction register; IR[11:9] = condition mask n,z,p; IR[8:0] = signed PC offset.
REQ-008 pcInc  input  1  fetch strobe; request PC <= PC + 1.
REQ-009 brStart  input  1  single-cycle request to evaluate the branch held in IR.
REQ-010 PC  output  16  current program counter.
REQ-011 brBusy  output  1  high while a branch evaluation is in progress.
REQ-012 brDone  output  1  one-cycle pulse on branch completion.
REQ-013 brTaken  output  1  branch outcome; valid only while brDone = 1, else 0.

Function
REQ-014 FSM states SHALL be IDLE, EVAL, UPDATE, DONE; encoding is free.
REQ-015 In IDLE with brStart = 1, the block SHALL capture cond = IR[11:9], off = sign-extended IR[8:0], and snapshot {N,Z,P}, then go to EVAL.
REQ-016 In EVAL, the block SHALL compute taken = |(cond & {Nsnap,Zsnap,Psnap}) and target = PC + off (mod 2^16), then go to UPDATE.
REQ-017 In UPDATE, the block SHALL load PC <= target if taken, else hold PC, then go to DONE.
REQ-018 In DONE, the block SHALL drive brDone = 1 and brTaken = taken for exactly one cycle, then return to IDLE.
REQ-019 brStart sampled on edge k SHALL produce brDone high during the cycle after edge k+3; any new PC value SHALL be visible in that same cycle.
REQ-020 brBusy SHALL be 1 in EVAL, UPDATE and DONE, and 0 in IDLE.
REQ-021 Flag or IR changes after the capture edge SHALL NOT affect the outcome of the current branch.
REQ-022 cond = 3'b000 SHALL never be taken; cond = 3'b111 SHALL always be taken when exactly one snapshot flag is set.
REQ-023 pcInc SHALL increment PC by 1 only in IDLE with brStart = 0; 16'hFFFF SHALL wrap to 16'h0000.
REQ-024 When pcInc and brStart are both 1 in IDLE, brStart SHALL win and pcInc SHALL be ignored.
REQ-025 pcInc and brStart asserted outside IDLE SHALL be ignored with no queuing.
REQ-026 Target arithmetic SHALL wrap modulo 2^16 in both directions (e.g., PC 16'h0002 + off -3 = 16'hFFFF).
REQ-027 Offset sign-extension SHALL replicate IR[8] into bits 15:9.

Reset
REQ-028 While reset = 0, the block SHALL force PC = RESET_PC, state = IDLE, brBusy = 0, brDone = 0, brTaken = 0, and clear the captured cond, off and flag snapshot.
REQ-029 Reset asserted mid-branch SHALL abort the branch with no brDone pulse and no PC update.
REQ-030 After reset deasserts, the first rising edge SHALL be able to accept brStart or pcInc.

Verification
REQ-031 Setup: reset, then pulse pcInc 5 times -> PC = 16'h0005, brBusy stays 0.
REQ-032 Setup: PC = 16'h0010, IR = 16'h0A05 (cond = 101, off = +5), N = 1. Stimulus: pulse brStart. Required: brDone and brTaken = 1 three cycles later, PC = 16'h0015.
REQ-033 Setup: same IR, Z = 1. Stimulus: pulse brStart. Required: brDone = 1, brTaken = 0, PC stays 16'h0010.
REQ-034 Setup: PC = 16'h0002, IR[8:0] = 9'h1FD (-3), cond = 111, P = 1. Stimulus: pulse brStart. Required: PC = 16'hFFFF. Follow-up: one pcInc. Required: PC = 16'h0000.
REQ-035 Stimulus: brStart and pcInc together in IDLE; flip the flags and pulse pcInc during EVAL. Required: outcome uses the captured flags, and PC does not increment.
REQ-036 Stimulus: brStart, then reset = 0 during UPDATE. Required: PC = RESET_PC immediately, no brDone pulse, state IDLE after release.

Source files
------------

// File: rtl/branch_ctl.sv
// Conditional PC-relative branch controller with a fetch-increment path.
// A four-state FSM captures the branch, evaluates it, updates the PC, then pulses done.
module branch_ctl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic [15:0] IR,
  input  logic        pcInc,
  input  logic        brStart,
  output logic [15:0] PC,
  output logic        brBusy,
  output logic        brDone,
  output logic        brTaken
);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  state_t      state;
  logic [2:0]  cond;
  logic [2:0]  flags;
  logic [15:0] off;
  logic [15:0] target;
  logic        taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      PC      <= RESET_PC;
      brBusy  <= 1'b0;
      brDone  <= 1'b0;
      brTaken <= 1'b0;
      cond    <= 3'b000;
      flags   <= 3'b000;
      off     <= 16'h0000;
      target  <= 16'h0000;
      taken   <= 1'b0;
    end else begin
      brDone  <= 1'b0;
      brTaken <= 1'b0;
      case (state)
        IDLE: begin
          // A branch request takes priority over a fetch increment.
          if (brStart) begin
            cond   <= IR[11:9];
            off    <= {{7{IR[8]}}, IR[8:0]};
            flags  <= {N, Z, P};
            brBusy <= 1'b1;
            state  <= EVAL;
          end else if (pcInc) begin
            PC <= PC + 16'd1;
          end
        end
        EVAL: begin
          taken  <= |(cond & flags);
          target <= PC + off;
          state  <= UPDATE;
        end
        UPDATE: begin
          if (taken) PC <= target;
          state <= DONE;
        end
        DONE: begin
          // Done/taken are registered, so they appear in the cycle after leaving DONE.
          brDone  <= 1'b1;
          brTaken <= taken;
          brBusy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
